// File: rtl/prog_count_pkg.sv
// Shared definitions for the programmable counter sequencing controller.
//   - pcc_state_e     : 3-bit FSM state encoding (also exported on state_out)
//   - PCC_WIDTH       : default counter width
//   - PCC_DEFAULT_LIMIT : terminal value loaded at reset
//   - PCC_TIMEOUT_CYC : default BCD ack timeout (only used with BCD_TIMEOUT_EN)
package prog_count_pkg;

  localparam int unsigned PCC_WIDTH         = 7;
  localparam int unsigned PCC_DEFAULT_LIMIT = 100;
  localparam int unsigned PCC_TIMEOUT_CYC   = 64;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCount   = 3'd1,
    StCapture = 3'd2,
    StConvert = 3'd3,
    StDone    = 3'd4
  } pcc_state_e;

endpackage

// File: rtl/prog_count_ctrl_timeout.sv
// pcc_timeout_timer: counts cycles spent in CONVERT and flags expiry.
// Only instantiated when BCD_TIMEOUT_EN is defined.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   en      in  high while the controller sits in CONVERT; low clears the count
//   expired out high during the TIMEOUT_CYC-th consecutive enabled cycle
module pcc_timeout_timer
  import prog_count_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = PCC_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_count_ctrl.sv
// prog_count_ctrl: sequencing controller for a WIDTH-bit run/clear counter.
// Runs the counter up to a programmable terminal value, captures it and hands it
// to a BCD converter over bcd_req/bcd_ack, then finishes or auto-restarts.
// Optional feature: define BCD_TIMEOUT_EN to abort CONVERT after TIMEOUT_CYC
// cycles without bcd_ack (sets sticky timeout_err). Port list is identical.
// Ports:
//   CLK, RST_N   clock, asynchronous active-low reset
//   start/stop   pulses; stop wins when both are high
//   continuous   level, sampled with bcd_ack; 1 = restart counting
//   limit_load, limit_in  load terminal value (IDLE only; 0 means 2^WIDTH)
//   count_in     counter value;  run  counter control (0 = clear, 1 = increment)
//   value_out    captured terminal value;  bcd_req/bcd_ack  converter handshake
//   tc           one-cycle terminal-count flag;  busy  COUNT/CAPTURE/CONVERT
//   state_out    state encoding;  timeout_err  sticky ack-timeout flag
module prog_count_ctrl
  import prog_count_pkg::*;
#(
  parameter int unsigned WIDTH         = PCC_WIDTH,
  parameter int unsigned DEFAULT_LIMIT = PCC_DEFAULT_LIMIT,
  parameter int unsigned TIMEOUT_CYC   = PCC_TIMEOUT_CYC
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic             limit_load,
  input  logic [WIDTH-1:0] limit_in,
  input  logic [WIDTH-1:0] count_in,
  output logic             run,
  output logic [WIDTH-1:0] value_out,
  output logic             bcd_req,
  input  logic             bcd_ack,
  output logic             tc,
  output logic             busy,
  output logic [2:0]       state_out,
  output logic             timeout_err
);

  localparam logic [WIDTH-1:0] LimitRst = WIDTH'(DEFAULT_LIMIT);

  pcc_state_e       state_q, state_d;
  logic             run_q, run_d;
  logic             bcd_req_q, bcd_req_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             terr_q, terr_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] term_val;
  logic             timeout_hit;

  // Stop one count early: run drops on the same edge the counter reaches the limit.
  // A limit of 0 wraps to all-ones here, giving a full 2^WIDTH count.
  assign term_val = limit_q - WIDTH'(1);

`ifdef BCD_TIMEOUT_EN
  pcc_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (CLK),
    .rst_n   (RST_N),
    .en      (state_q == StConvert),
    .expired (timeout_hit)
  );
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    run_d     = 1'b0;
    bcd_req_d = 1'b0;
    tc_d      = 1'b0;
    terr_d    = terr_q;
    value_d   = value_q;
    limit_d   = limit_q;
    unique case (state_q)
      StIdle: begin
        if (limit_load) begin
          limit_d = limit_in;
        end
        if (!stop && start) begin
          state_d = StCount;
          run_d   = 1'b1;
          terr_d  = 1'b0;
        end
      end
      StCount: begin
        if (stop) begin
          state_d = StIdle;
        end else if (count_in == term_val) begin
          state_d = StCapture;
          tc_d    = 1'b1;
        end else begin
          run_d = 1'b1;
        end
      end
      StCapture: begin
        // Counter holds the terminal value this cycle and clears at this edge.
        value_d   = count_in;
        state_d   = StConvert;
        bcd_req_d = 1'b1;
      end
      StConvert: begin
        if (bcd_ack) begin
          if (continuous) begin
            state_d = StCount;
            run_d   = 1'b1;
          end else begin
            state_d = StDone;
          end
        end else if (timeout_hit) begin
          state_d = StIdle;
          terr_d  = 1'b1;
        end else begin
          bcd_req_d = 1'b1;
        end
      end
      StDone: begin
        if (stop) begin
          state_d = StIdle;
        end else if (start) begin
          state_d = StCount;
          run_d   = 1'b1;
          terr_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d == StCount) || (state_d == StCapture) || (state_d == StConvert);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      run_q     <= 1'b0;
      bcd_req_q <= 1'b0;
      tc_q      <= 1'b0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
      value_q   <= '0;
      limit_q   <= LimitRst;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      bcd_req_q <= bcd_req_d;
      tc_q      <= tc_d;
      busy_q    <= busy_d;
      terr_q    <= terr_d;
      value_q   <= value_d;
      limit_q   <= limit_d;
    end
  end

  assign run         = run_q;
  assign bcd_req     = bcd_req_q;
  assign tc          = tc_q;
  assign busy        = busy_q;
  assign value_out   = value_q;
  assign state_out   = state_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_prog_count_ctrl.sv
// Self-checking bench for prog_count_ctrl. A 7-bit run/clear counter model closes
// the loop on count_in; expectations come from the timing rules (start at E0,
// counter reaches L at E_L, tc after E_L, value/req after E_(L+1)).
module tb_prog_count_ctrl;

  localparam int W = 7;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         start = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic         limit_load = 1'b0;
  logic [W-1:0] limit_in = '0;
  logic [W-1:0] count_in;
  logic         run, bcd_req, tc, busy, timeout_err;
  logic         bcd_ack = 1'b0;
  logic [W-1:0] value_out;
  logic [2:0]   state_out;

  logic [W-1:0] cnt = '0;
  logic [W-1:0] exp_value = '0;
  int           n_checks = 0;
  int           n_pass = 0;

  always #5 CLK = ~CLK;

  // External counter: clear when run = 0, increment when run = 1.
  always @(posedge CLK) cnt <= run ? cnt + 7'd1 : 7'd0;
  assign count_in = cnt;

  prog_count_ctrl #(
    .WIDTH         (W),
    .DEFAULT_LIMIT (100),
    .TIMEOUT_CYC   (8)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .start       (start),
    .stop        (stop),
    .continuous  (continuous),
    .limit_load  (limit_load),
    .limit_in    (limit_in),
    .count_in    (count_in),
    .run         (run),
    .value_out   (value_out),
    .bcd_req     (bcd_req),
    .bcd_ack     (bcd_ack),
    .tc          (tc),
    .busy        (busy),
    .state_out   (state_out),
    .timeout_err (timeout_err)
  );

  task automatic go_idle();
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    n_checks++;
    if (state_out !== 3'd0 || run !== 1'b0) begin
      $display("FAIL go_idle: state=%0d run=%b, want state=0 run=0", state_out, run);
    end else n_pass++;
  endtask

  task automatic load_limit(input int v);
    limit_load = 1'b1;
    limit_in = W'(v);
    @(negedge CLK);
    limit_load = 1'b0;
  endtask

  // Caller has just driven the trigger (start or bcd_ack) at a negedge.
  task automatic count_period(input int l, input bit load_mid);
    logic [W-1:0] lm;
    lm = W'(l);
    for (int k = 0; k < l; k++) begin
      @(negedge CLK);
      start = 1'b0;
      bcd_ack = 1'b0;
      if (load_mid && k == 1) begin
        limit_load = 1'b1;
        limit_in = W'($urandom_range(30, 60));
      end else limit_load = 1'b0;
      n_checks++;
      if ({run, tc, bcd_req, busy} !== 4'b1001 || state_out !== 3'd1 || count_in !== W'(k)) begin
        $display("FAIL count k=%0d: run/tc/req/busy=%b state=%0d cnt=%0d, want 1001 state=1 cnt=%0d",
                 k, {run, tc, bcd_req, busy}, state_out, count_in, k);
      end else n_pass++;
    end
    @(negedge CLK);
    start = 1'b0;
    bcd_ack = 1'b0;
    limit_load = 1'b0;
    n_checks++;
    if ({run, tc, bcd_req, busy} !== 4'b0101 || state_out !== 3'd2 || count_in !== lm) begin
      $display("FAIL capture L=%0d: run/tc/req/busy=%b state=%0d cnt=%0d, want 0101 state=2 cnt=%0d",
               l, {run, tc, bcd_req, busy}, state_out, count_in, lm);
    end else n_pass++;
    @(negedge CLK);
    exp_value = lm;
    n_checks++;
    if ({run, tc, bcd_req, busy} !== 4'b0011 || state_out !== 3'd3 || value_out !== lm ||
        count_in !== 7'd0) begin
      $display("FAIL convert L=%0d: run/tc/req/busy=%b state=%0d value=%0d cnt=%0d, want 0011 3 %0d 0",
               l, {run, tc, bcd_req, busy}, state_out, value_out, count_in, lm);
    end else n_pass++;
  endtask

  task automatic ack_wait(input int d);
    repeat (d) begin
      @(negedge CLK);
      n_checks++;
      if (bcd_req !== 1'b1 || state_out !== 3'd3 || tc !== 1'b0) begin
        $display("FAIL ack_wait: req=%b state=%0d tc=%b, want req=1 state=3 tc=0",
                 bcd_req, state_out, tc);
      end else n_pass++;
    end
  endtask

  task automatic ack_to_done();
    continuous = 1'b0;
    bcd_ack = 1'b1;
    @(negedge CLK);
    bcd_ack = 1'b0;
    n_checks++;
    if ({run, tc, bcd_req, busy} !== 4'b0000 || state_out !== 3'd4 || value_out !== exp_value) begin
      $display("FAIL done: run/tc/req/busy=%b state=%0d value=%0d, want 0000 state=4 value=%0d",
               {run, tc, bcd_req, busy}, state_out, value_out, exp_value);
    end else n_pass++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({run, tc, bcd_req, busy, timeout_err} !== 5'b0 || state_out !== 3'd0 || value_out !== 7'd0) begin
      $display("FAIL reset_hold: outs=%b state=%0d value=%0d, want 0 0 0",
               {run, tc, bcd_req, busy, timeout_err}, state_out, value_out);
    end else n_pass++;
    RST_N = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({run, tc, bcd_req, busy, timeout_err} !== 5'b0 || state_out !== 3'd0 || count_in !== 7'd0) begin
      $display("FAIL reset_release: outs=%b state=%0d cnt=%0d, want 0 0 0",
               {run, tc, bcd_req, busy, timeout_err}, state_out, count_in);
    end else n_pass++;
  endtask

  task automatic test_basic();
    load_limit(5);
    start = 1'b1;
    count_period(5, 1'b0);
    ack_wait(3);
    ack_to_done();
    repeat (3) @(negedge CLK);
    n_checks++;
    if (run !== 1'b0 || state_out !== 3'd4 || count_in !== 7'd0) begin
      $display("FAIL done_hold: run=%b state=%0d cnt=%0d, want 0 4 0", run, state_out, count_in);
    end else n_pass++;
    for (int i = 0; i < 4; i++) begin
      int l;
      l = $urandom_range(2, 40);
      go_idle();
      load_limit(l);
      start = 1'b1;
      count_period(l, 1'b0);
      ack_wait($urandom_range(1, 5));
      ack_to_done();
    end
  endtask

  task automatic test_continuous();
    for (int r = 0; r < 2; r++) begin
      int l;
      int periods;
      l = (r == 0) ? 3 : $urandom_range(2, 12);
      periods = (r == 0) ? 2 : $urandom_range(2, 3);
      go_idle();
      load_limit(l);
      continuous = 1'b1;
      start = 1'b1;
      count_period(l, 1'b0);
      for (int p = 1; p < periods; p++) begin
        ack_wait((r == 0) ? 2 : $urandom_range(1, 4));
        bcd_ack = 1'b1;
        count_period(l, 1'b0);
      end
      ack_wait(2);
      ack_to_done();
    end
  endtask

  task automatic test_abort();
    for (int r = 0; r < 2; r++) begin
      int k;
      k = (r == 0) ? 2 : $urandom_range(0, 8);
      go_idle();
      load_limit(12);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (k) @(negedge CLK);
      n_checks++;
      if (count_in !== W'(k) || run !== 1'b1) begin
        $display("FAIL abort_pre k=%0d: cnt=%0d run=%b, want cnt=%0d run=1", k, count_in, run, k);
      end else n_pass++;
      stop = 1'b1;
      @(negedge CLK);
      stop = 1'b0;
      n_checks++;
      if ({run, tc, bcd_req, busy} !== 4'b0000 || state_out !== 3'd0 || value_out !== exp_value) begin
        $display("FAIL abort k=%0d: run/tc/req/busy=%b state=%0d value=%0d, want 0000 0 %0d",
                 k, {run, tc, bcd_req, busy}, state_out, value_out, exp_value);
      end else n_pass++;
      @(negedge CLK);
      n_checks++;
      if (count_in !== 7'd0 || tc !== 1'b0 || state_out !== 3'd0) begin
        $display("FAIL abort_clear k=%0d: cnt=%0d tc=%b state=%0d, want 0 0 0",
                 k, count_in, tc, state_out);
      end else n_pass++;
    end
  endtask

  task automatic test_boundaries();
    // Limit 0: full 128-count wrap.
    go_idle();
    load_limit(0);
    start = 1'b1;
    count_period(128, 1'b0);
    ack_wait(1);
    ack_to_done();
    // Limit 1: terminal detected on the first COUNT cycle.
    go_idle();
    load_limit(1);
    start = 1'b1;
    count_period(1, 1'b0);
    ack_to_done();
    // limit_load while counting must not change the terminal value.
    go_idle();
    load_limit(6);
    start = 1'b1;
    count_period(6, 1'b1);
    ack_to_done();
    start = 1'b1;
    count_period(6, 1'b0);
    ack_to_done();
    // start and stop together in IDLE stay in IDLE.
    go_idle();
    start = 1'b1;
    stop = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    stop = 1'b0;
    n_checks++;
    if (state_out !== 3'd0 || run !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL start_stop_idle: state=%0d run=%b busy=%b, want 0 0 0", state_out, run, busy);
    end else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (state_out !== 3'd0 || count_in !== 7'd0) begin
      $display("FAIL start_stop_idle2: state=%0d cnt=%0d, want 0 0", state_out, count_in);
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    go_idle();
    load_limit(4);
    start = 1'b1;
    count_period(4, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    n_checks++;
    if ({run, tc, bcd_req, busy, timeout_err} !== 5'b0 || state_out !== 3'd0 || value_out !== 7'd0) begin
      $display("FAIL reset_mid: outs=%b state=%0d value=%0d, want 0 0 0",
               {run, tc, bcd_req, busy, timeout_err}, state_out, value_out);
    end else n_pass++;
    @(negedge CLK);
    RST_N = 1'b1;
    exp_value = '0;
    n_checks++;
    if (count_in !== 7'd0) begin
      $display("FAIL reset_mid_cnt: cnt=%0d, want 0", count_in);
    end else n_pass++;
    start = 1'b1;
    count_period(100, 1'b0);
    ack_to_done();
  endtask

  task automatic test_timeout();
    go_idle();
    load_limit(4);
    start = 1'b1;
    count_period(4, 1'b0);
`ifdef BCD_TIMEOUT_EN
    ack_wait(7);
    @(negedge CLK);
    n_checks++;
    if (bcd_req !== 1'b0 || timeout_err !== 1'b1 || state_out !== 3'd0 || busy !== 1'b0) begin
      $display("FAIL timeout: req=%b terr=%b state=%0d busy=%b, want 0 1 0 0",
               bcd_req, timeout_err, state_out, busy);
    end else n_pass++;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (timeout_err !== 1'b1 || state_out !== 3'd0) begin
      $display("FAIL timeout_sticky: terr=%b state=%0d, want 1 0", timeout_err, state_out);
    end else n_pass++;
    start = 1'b1;
    count_period(4, 1'b0);
    n_checks++;
    if (timeout_err !== 1'b0) begin
      $display("FAIL timeout_clear: terr=%b, want 0", timeout_err);
    end else n_pass++;
    ack_to_done();
`else
    for (int i = 0; i < 110; i++) begin
      @(negedge CLK);
      n_checks++;
      if (bcd_req !== 1'b1 || timeout_err !== 1'b0 || state_out !== 3'd3) begin
        $display("FAIL no_timeout cyc=%0d: req=%b terr=%b state=%0d, want 1 0 3",
                 i, bcd_req, timeout_err, state_out);
      end else n_pass++;
    end
    ack_to_done();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_continuous();
    test_abort();
    test_boundaries();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_count_ctrl.md
Name: prog_count_ctrl

Overview:
Sequencing controller for the 7-bit run/clear binary counter in the programmable counter / BCD converter datapath. It drives the counter's run input and watches its count value. It stops the count at a programmable terminal value, captures that value, and hands it to the BCD converter over a req/ack handshake. It then either finishes or restarts automatically.

Parameters:
WIDTH, 7, counter width; it matches the 7-bit counter.
DEFAULT_LIMIT, 100, terminal value loaded at reset.
TIMEOUT_CYC, 64, BCD ack timeout in cycles; used only when BCD_TIMEOUT_EN is defined.

Ports:
CLK  in  1  system clock; all logic on rising edge
RST_N  in  1  asynchronous active-low reset
start  in  1  pulse; begin counting
stop  in  1  pulse; abort counting
continuous  in  1  level; sampled on BCD ack; 1 = auto-restart
limit_load  in  1  load limit_in into limit register
limit_in  in  WIDTH  terminal count value; 0 means 2^WIDTH
count_in  in  WIDTH  current counter value
run  out  1  to counter; 0 = synchronous clear, 1 = increment
value_out  out  WIDTH  captured terminal value for the BCD converter
bcd_req  out  1  conversion request
bcd_ack  in  1  conversion accepted/complete
tc  out  1  one-cycle terminal-count flag
busy  out  1  high in COUNT, CAPTURE, CONVERT
state_out  out  3  state encoding, for debug
timeout_err  out  1  sticky BCD timeout flag; tied 0 without macro

Behaviour:
- Reset (RST_N low, async):
  - state = IDLE; run, bcd_req, tc, busy, timeout_err = 0.
  - value_out = 0; limit_reg = DEFAULT_LIMIT.
- All outputs are registered.
- State encoding: IDLE=0, COUNT=1, CAPTURE=2, CONVERT=3, DONE=4.
- IDLE:
  - run = 0, so the counter is held at 0.
  - limit_load captures limit_in. limit_load is ignored in every other state.
  - start goes to COUNT, with run = 1 from the same edge.
- COUNT:
  - stop goes to IDLE; run = 0.
  - Otherwise, count_in == limit_reg − 1 (WIDTH-bit wrap) goes to CAPTURE; run = 0 at that edge.
  - The counter increments to exactly limit_reg at that same edge, so there is no overshoot.
  - start is ignored.
- CAPTURE (one cycle):
  - tc = 1.
  - value_out <= count_in, which equals limit_reg mod 2^WIDTH.
  - Next state is CONVERT with bcd_req = 1. The counter clears at this edge.
- CONVERT:
  - bcd_req is held high until bcd_ack is sampled high.
  - On ack: bcd_req = 0.
  - If continuous = 1, go to COUNT with run = 1; otherwise go to DONE.
  - stop and start are ignored in this state.
- DONE:
  - start goes to COUNT.
  - stop goes to IDLE.
- Simultaneous start and stop: stop wins; the state stays in or goes to IDLE.
- Latency: for start sampled at edge E0, the counter reaches L at edge E_L.
  - tc is high in the cycle after E_L.
  - value_out is valid and bcd_req is high after E_(L+1).
- limit_reg = 0 gives 128 counts. The counter wraps to 0, value_out = 0, and tc fires once.
- limit_reg = 1: terminal is detected immediately after entering COUNT (count_in == 0).
- Reset during any state: run drops immediately, and the counter clears on its next CLK edge.

Optional Feature:
BCD_TIMEOUT_EN
- When defined, an internal counter runs while in CONVERT.
  - If TIMEOUT_CYC cycles pass without bcd_ack: bcd_req = 0, timeout_err = 1 (sticky), next state IDLE.
  - timeout_err clears on the next accepted start.
- When not defined: CONVERT waits indefinitely and timeout_err is constant 0.
- The port list is identical in both builds.

Decomposition:
- Package prog_count_pkg holds:
  - the state enumeration (3-bit);
  - the WIDTH default;
  - the DEFAULT_LIMIT constant;
  - the TIMEOUT_CYC default.
- One sub-module is natural: pcc_timeout_timer, the CONVERT-state timeout counter. It is instantiated only under BCD_TIMEOUT_EN.
- The FSM, limit register and capture register stay flat in prog_count_ctrl.

Test Plan:
1. Basic run: reset, limit_load with limit_in = 5, start, paired with the counter model.
   - Expect run high for 5 edges and tc for one cycle when the counter reads 5.
   - Expect value_out = 5 and bcd_req = 1.
   - Drive bcd_ack 3 cycles later: bcd_req drops, state_out = 4, run stays 0.
2. Continuous mode: continuous = 1, limit = 3, ack 2 cycles after req.
   - Two full periods, each with value_out = 3 and one tc.
   - run re-asserts on the edge after ack; the counter never exceeds 3.
3. Abort: stop pulse while count_in = 2.
   - run = 0 next edge, state_out = 0, no tc.
   - value_out keeps its previous value and the counter clears.
4. Boundaries:
   - limit_in = 0: 128 counts, value_out = 0, one tc.
   - limit_in = 1: tc in the cycle after count_in reaches 1.
   - limit_load during COUNT: ignored, and the old limit still terminates the count.
   - start and stop together in IDLE: state stays IDLE.
5. Reset mid-operation: assert RST_N low during CONVERT with bcd_req = 1.
   - All outputs are 0 immediately and state_out = 0.
   - limit_reg returns to 100 (the next start terminates at 100).
6. Timeout: build with BCD_TIMEOUT_EN, TIMEOUT_CYC = 8, limit = 4, no ack.
   - 8 cycles after req: bcd_req = 0, timeout_err = 1, state IDLE; the next start clears timeout_err.
   - Without the macro: bcd_req stays high for 100+ cycles and timeout_err = 0.
